// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory slave with byte/half/word loads and stores.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  rw_type_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    type_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   word, sh, load, wd;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [3:0]    be;
  logic          bad_type, misalign, err, resp;
  logic          unused_bits;
  assign unused_bits = ^addr_i[31:AW+2];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          we_q    <= we_i;
          addr_q  <= addr_i[AW+1:0];
          wdata_q <= wdata_i;
          type_q  <= rw_type_i;
          cnt     <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
          state   <= WAIT_STATES > 0 ? WAIT : RESP;
        end
        WAIT: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
  assign idx  = addr_q[AW+1:2];
  assign word = mem[idx];
  assign sh   = word >> {addr_q[1:0], 3'b000};
  assign b    = sh[7:0];
  assign h    = addr_q[1] ? word[31:16] : word[15:0];
  // type_q[2] marks the unsigned load variants, so it suppresses sign extension
  assign load = type_q[1:0] == 2'b00 ? {{24{~type_q[2] & b[7]}}, b}
              : type_q[1:0] == 2'b01 ? {{16{~type_q[2] & h[15]}}, h} : word;
  assign wd   = type_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
              : type_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign be   = type_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
              : type_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bad_type = type_q[1:0] == 2'b11 || type_q == 3'b110 || (we_q && type_q[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = (type_q[1:0] == 2'b01 && addr_q[0]) || (type_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign err     = bad_type | misalign;
  assign resp    = state == RESP;
  assign ready_o = resp;
  assign err_o   = resp & err;
  assign rdata_o = resp && !err && !we_q ? load : 32'd0;
  // Storage has no reset; a reset landing on the RESP edge still suppresses the write
  always_ff @(posedge clk) begin
    if (rst_n && resp && we_q && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array reference model.
module tb_dmem_responder;
  localparam int DEPTH = 1024, WS = 1;
  logic        clk = 0, rst_n = 0, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [2:0]  rwt = 0;
  logic [31:0] rdata;
  logic        ready, err;
  int          errors = 0, checks = 0;
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] got_rd;
  logic        got_err;
  int          got_lat;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rw_type_i(rwt), .rdata_o(rdata), .ready_o(ready), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] t, output logic [31:0] rd, output logic er);
    int n, base;
    logic [31:0] v;
    n  = t[1:0] == 2'b00 ? 1 : t[1:0] == 2'b01 ? 2 : 4;
    er = t == 3 || t >= 6 || (w && t >= 4);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % n != 0) er = 1;
`endif
    rd = 0;
    if (er) return;
    base = int'(a % (DEPTH*4));
    base = base - base % n;
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base+i];
      if (t < 4 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] t, input bit hold);
    @(negedge clk);
    req = 1; we = w; addr = a; wdata = wd; rwt = t;
    got_lat = 0;
    do begin
      @(negedge clk);
      got_lat++;
    end while (!ready && got_lat < 20);
    got_rd  = rdata;
    got_err = err;
    if (hold) @(negedge clk);
    req = 0;
  endtask

  task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] t, input bit hold);
    logic [31:0] erd;
    logic        eer;
    access(w, a, wd, t, hold);
    model(w, a, wd, t, erd, eer);
    check({tag, " latency"}, got_lat, WS + 1);
    check({tag, " err"}, got_err, eer);
    check({tag, " rdata"}, got_rd, erd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    repeat (3) @(negedge clk);
    check("reset ready", ready, 0);
    check("reset err", err, 0);
    check("reset rdata", rdata, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) run("init", 1, i * 4, $urandom, 3'b010, 0);

    run("sw 0x10", 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
    run("lw 0x10", 0, 32'h10, 0, 3'b010, 0);
    check("lw 0x10 value", got_rd, 32'hDEADBEEF);
    run("sb 0x13", 1, 32'h13, 32'h7F, 3'b000, 0);
    run("lb 0x13", 0, 32'h13, 0, 3'b000, 0);
    check("lb 0x13 value", got_rd, 32'h0000007F);
    run("lbu 0x12", 0, 32'h12, 0, 3'b100, 0);
    check("lbu 0x12 value", got_rd, 32'h000000AD);
    run("lw merged", 0, 32'h10, 0, 3'b010, 0);
    check("lw merged value", got_rd, 32'h7FADBEEF);
    run("sh 0x22", 1, 32'h22, 32'h8001, 3'b001, 0);
    run("lh 0x22", 0, 32'h22, 0, 3'b001, 0);
    check("lh 0x22 value", got_rd, 32'hFFFF8001);
    run("lhu 0x22", 0, 32'h22, 0, 3'b101, 0);
    check("lhu 0x22 value", got_rd, 32'h00008001);
    run("sw wrap", 1, 32'h1000, 32'h12345678, 3'b010, 0);
    run("lw wrap", 0, 32'h0, 0, 3'b010, 0);
    check("lw wrap value", got_rd, 32'h12345678);
    run("store bu", 1, 32'h0, 32'hFFFF_FFFF, 3'b100, 0);
    check("store bu err", got_err, 1);
    run("lw after bad store", 0, 32'h0, 0, 3'b010, 0);
    check("bad store no write", got_rd, 32'h12345678);
    run("lw 0x02", 0, 32'h2, 0, 3'b010, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misaligned lw err", got_err, 1);
    check("misaligned lw rdata", got_rd, 0);
`else
    check("unaligned lw value", got_rd, 32'h12345678);
`endif

    // reset lands while the store sits in its wait state
    @(negedge clk);
    req = 1; we = 1; addr = 32'h20; wdata = 32'hCAFEF00D; rwt = 3'b010;
    @(negedge clk);
    rst_n = 0; req = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abandoned ready", ready, 0);
      check("abandoned err", err, 0);
    end
    run("lw after abandon", 0, 32'h20, 0, 3'b010, 0);

    run("held req", 0, 32'h4, 0, 3'b010, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no reaccept ready", ready, 0);
      check("idle rdata", rdata, 0);
    end

    for (int k = 0; k < 200; k++) begin
      ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      run("random", 1'($urandom_range(0, 1)), ra, $urandom, 3'($urandom_range(0, 7)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words (power of two, >=2).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_i  input  1  request valid from the core's memory stage.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port wdata_i  input  32  store data, right-aligned.
REQ-009 SHALL have port rw_type_i  input  3  access type, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port rdata_o  output  32  load result, extended to 32 bits.
REQ-011 SHALL have port ready_o  output  1  one-cycle response strobe.
REQ-012 SHALL have port err_o  output  1  access error, valid only while ready_o=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE with req_i=1, SHALL latch we_i, addr_i, wdata_i and rw_type_i, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-015 In WAIT, SHALL decrement a wait counter loaded with WAIT_STATES-1 and go to RESP on the cycle the counter is 0.
REQ-016 In RESP, SHALL assert ready_o=1 for exactly one cycle, then return to IDLE.
REQ-017 Response latency SHALL be WAIT_STATES+1 cycles from the accepting edge to the ready_o cycle.
REQ-018 SHALL ignore req_i outside IDLE, including the RESP cycle; the initiator holds req_i until it sees ready_o.
REQ-019 SHALL select the word index as latched addr[log2(DEPTH_WORDS)+1:2]; higher address bits wrap modulo the depth.
REQ-020 Byte access SHALL use lane addr[1:0]; halfword access SHALL use lane addr[1] (addr[0] ignored); word access SHALL ignore addr[1:0].
REQ-021 Stores SHALL commit in the RESP cycle to the selected lanes only (SB one byte, SH two bytes, SW four bytes); other lanes are unchanged.
REQ-022 Loads SHALL drive rdata_o in the RESP cycle: B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-023 Store with rw_type 100 or 101, and any access with rw_type 011, 110 or 111, SHALL give err_o=1 and rdata_o=0, with no memory write.
REQ-024 rdata_o and err_o SHALL be 0 whenever ready_o=0.
REQ-025 A load issued after a store to the same word SHALL return the updated data.

Reset
REQ-026 While rst_n=0 at a clock edge, SHALL enter IDLE and drive ready_o=0, err_o=0, rdata_o=0, and wait counter=0.
REQ-027 Reset asserted mid-transaction SHALL abandon that transaction with no write and no ready_o.
REQ-028 Storage contents SHALL NOT be reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN defined: halfword access with addr[0]=1, or word access with addr[1:0]!=0, SHALL complete with ready_o=1, err_o=1, rdata_o=0, and no write.
REQ-030 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL follow REQ-020 with err_o=0 and no misalignment logic.

Verification
REQ-031 WAIT_STATES=1; SW 0xDEADBEEF @0x10, then LW @0x10 -> each ready_o exactly 2 cycles after acceptance; rdata=0xDEADBEEF, err=0.
REQ-032 After REQ-031, SB 0x7F @0x13, then LB @0x13 and LBU @0x12 -> LB rdata=0x0000007F; LBU rdata=0x000000AD; word @0x10 reads 0x7FADBEEF.
REQ-033 SH 0x8001 @0x22, then LH @0x22 and LHU @0x22 -> 0xFFFF8001 and 0x00008001.
REQ-034 DEPTH_WORDS=1024; SW 0x12345678 @0x1000, then LW @0x0000 -> 0x12345678 (wrap).
REQ-035 Store with rw_type=100 -> ready_o=1, err_o=1, memory unchanged; with DMEM_MISALIGN_TRAP_EN, LW @0x02 -> err_o=1 and rdata=0.
REQ-036 rst_n=0 in the WAIT cycle of an SW -> no ready_o and the target word is unchanged; a req_i held through RESP is not re-accepted until IDLE.
